// File: rtl/isqrt_iter_hs.sv
`default_nettype none
// ============================================================================
//  Module   : isqrt_iter_hs
//  Purpose  : Iterative y = floor(sqrt(x)), one result bit per clock,
//             restoring digit-by-digit method with valid/ready handshake.
//  Revision : 1.0
// ============================================================================
module isqrt_iter_hs #(
    parameter int  N_BITS_X = 32,
    localparam int N_BITS_Y = N_BITS_X / 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                x_vld,
    input  logic [N_BITS_X-1:0] x,
    output logic                x_rdy,
    output logic                y_vld,
    output logic [N_BITS_Y-1:0] y,
    output logic                busy,
    output logic                drop_err
);

    localparam int                 c_CNT_W    = $clog2(N_BITS_Y);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(N_BITS_Y - 1);

    if ((N_BITS_X % 2 != 0) || (N_BITS_X < 4)) begin : g_bad_width
        $error("N_BITS_X must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [N_BITS_X-1:0]   xs_q;
    logic [N_BITS_Y+1:0]   rem_q;
    logic [N_BITS_Y-1:0]   root_q;
    logic [c_CNT_W-1:0]    cnt_q;
    logic [N_BITS_Y-1:0]   y_q;
    logic                  drop_err_q;

    logic [N_BITS_Y+1:0]   w_rem_sh;
    logic [N_BITS_Y+1:0]   w_trial;
    logic [N_BITS_Y+1:0]   rem_d;
    logic [N_BITS_Y-1:0]   root_d;
    logic                  w_unused_rem;

    // Before any shift the remainder is bounded by 2*root < 2^N_BITS_Y,
    // so its two top bits are always zero at this point.
    assign w_unused_rem = ^rem_q[N_BITS_Y+1:N_BITS_Y];

    always_comb begin
        w_rem_sh = {rem_q[N_BITS_Y-1:0], xs_q[N_BITS_X-1 -: 2]};
        w_trial  = {root_q, 2'b01};
        rem_d    = w_rem_sh;
        root_d   = {root_q[N_BITS_Y-2:0], 1'b0};
        if (w_rem_sh >= w_trial) begin
            rem_d  = w_rem_sh - w_trial;
            root_d = {root_q[N_BITS_Y-2:0], 1'b1};
        end
    end

    assign x_rdy    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy     = (state_q == S_CALC);
    assign y_vld    = (state_q == S_DONE);
    assign y        = y_q;
    assign drop_err = drop_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            xs_q       <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            y_q        <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (x_vld && !x_rdy) begin
                drop_err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (x_vld) begin
                        xs_q    <= x;
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    xs_q   <= {xs_q[N_BITS_X-3:0], 2'b00};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST_CNT) begin
                        y_q     <= root_d;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/isqrt_iter_hs.md
Name: isqrt_iter_hs

Overview:
Iterative integer square-root unit, y = floor(sqrt(x)), computed one result bit per clock with the restoring digit-by-digit method. It is the isqrt engine instantiated beside the sqrt-formula FSMs and drives their isqrt_*_x / isqrt_*_y ports. One operation is in flight at a time. A result cycle also accepts the next operand, so an FSM that issues its next request in the y_vld cycle runs without bubbles.

Parameters:
N_BITS_X, 32, operand width; must be even and >= 4.
N_BITS_Y, N_BITS_X/2, result width (derived, not overridable).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset (rst==0 at the edge resets).
x_vld  input  1  operand valid; sampled only when x_rdy==1.
x  input  N_BITS_X  unsigned operand.
x_rdy  output  1  unit can accept an operand this cycle.
y_vld  output  1  one-cycle result strobe.
y  output  N_BITS_Y  unsigned result; held until the next result.
busy  output  1  operation in progress (state CALC).
drop_err  output  1  sticky flag: x_vld was asserted while x_rdy==0.

Behaviour:
- Reset (rst==0 at an edge), from any state:
  - state=IDLE, y_vld=0, y=0, drop_err=0, internal regs cleared.
  - Any operation in progress is aborted; no y_vld follows.
- States: IDLE, CALC, DONE.
  - x_rdy = (state==IDLE || state==DONE).
  - busy = (state==CALC).
  - y_vld = (state==DONE).
- Accept: edge E0 with x_rdy & x_vld:
  - load xs<=x, rem<=0, root<=0, cnt<=0; state->CALC.
  - Applies in IDLE and in DONE.
- DONE with no x_vld: ->IDLE. DONE lasts exactly one cycle.
- CALC iteration, one per edge:
  - rem_sh = {rem, xs[N_BITS_X-1 -: 2]}, N_BITS_Y+2 bits.
  - trial = {root, 2'b01}.
  - If rem_sh >= trial: rem<=rem_sh-trial, root<={root,1}; else rem<=rem_sh, root<={root,0}.
  - xs<<=2; cnt++.
  - On the iteration with cnt==N_BITS_Y-1: y<=final root, state->DONE.
- Latency: accept at E0 -> y_vld high during the cycle starting at edge E0+N_BITS_Y (16 for the default). Throughput: one result per N_BITS_Y cycles.
- Arithmetic:
  - rem and trial are N_BITS_Y+2 bits wide; the subtraction never underflows when taken.
  - Comparison is unsigned.
  - No rounding; y fits N_BITS_Y exactly for every x.
- y changes only at the edge entering DONE (or at reset). It is stable while y_vld==0.
- x_vld during CALC:
  - operand ignored; computation unaffected;
  - drop_err<=1, sticky until reset.
- x_vld==1 in DONE: result strobe and acceptance happen in the same cycle; the next y_vld follows N_BITS_Y cycles later.
- x is don't-care when x_vld==0 or x_rdy==0.
- No combinational path from x or x_vld to any output. x_rdy, busy and y_vld decode from the state register only.

Test Plan:
- Reset, then x=0 / x=1 / x=2 / x=3 / x=4 in separate operations -> y=0,1,1,1,2; each y_vld exactly 16 cycles after accept and one cycle wide.
- x=0xFFFFFFFF -> y=0xFFFF. x=0xFFFE0001 -> y=0xFFFF. x=0xFFFE0000 -> y=0xFFFE.
- Back-to-back: x=16 accepted; x=81 presented exactly in the y_vld cycle -> y=4 at +16, y=9 at +32, no IDLE cycle between; drop_err stays 0.
- x_vld=1 with x=100 at cycle 5 of a CALC on x=1000000 -> y=1000 unchanged, x=100 never produces a result, drop_err=1 and stays 1.
- rst=0 at CALC cycle 8 of x=49, released next cycle -> no y_vld, y=0, x_rdy=1 after release; a new x=49 -> y=7 at +16.
- Random sweep of 10k operands plus 2^k, 2^k-1, k^2, k^2-1 corner values, against a model -> y*y <= x < (y+1)*(y+1) for every result; y_vld count equals accept count.
